// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// Consumers: m_fetch_fifo and m_fetch_queue.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h00000020;
   localparam int          DEPTH_DEF = 4;
   localparam int          AW_DEF    = 12;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc;
   } entry_t;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_e;

endpackage

// File: rtl/m_fetch_fifo.sv
// Circular entry store for the fetch queue: wrapping pointers plus an occupancy count.
// clear has priority over push and pop in the same cycle.
module m_fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  entry_t                   din,
   output entry_t                   head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);

   entry_t          mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/m_fetch_queue.sv
// Instruction fetch queue: issues synchronous imem reads and buffers {ir, pc} for decode.
// Optional FETCH_QUEUE_STATS_EN adds pop and flush counters (r_nfetch, r_nflush).
//
// Handshake: an entry transfers to decode on a rising edge where w_valid && w_ready;
// w_valid never depends on w_ready, and the head entry is stable while w_ready is low.
module m_fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic            w_clk,
   input  logic            w_rst_n,
   input  logic            w_redir,
   input  logic [31:0]     w_redir_pc,
   input  logic            w_halt,
   output logic            w_imem_re,
   output logic [AW-1:0]   w_imem_addr,
   input  logic [31:0]     w_imem_data,
   output logic            w_valid,
   input  logic            w_ready,
   output logic [31:0]     w_ir,
   output logic [31:0]     w_pc,
   output logic [31:0]     w_pc4,
   output state_e          w_state
`ifdef FETCH_QUEUE_STATS_EN
   ,
   output logic [31:0]     r_nfetch,
   output logic [31:0]     r_nflush
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_e          state;
   state_e          state_nxt;
   logic [31:0]     pc;
   logic [31:0]     issue_pc;
   logic            inflight;
   logic [CW-1:0]   count;
   logic [CW:0]     occupancy;
   logic            issue;
   logic            flush;
   logic            push;
   logic            pop;
   logic            empty;
   entry_t          head;
   entry_t          din;
   logic            unused_redir_lsb;

   assign unused_redir_lsb = ^w_redir_pc[1:0];

   // State register
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) state <= RUN;
      else          state <= state_nxt;
   end

   // Next state: HALTED is sticky until reset
   always_comb begin
      state_nxt = state;
      if (state == RUN && w_halt) state_nxt = HALTED;
   end

   // Outputs of the FSM: issue permission and redirect acceptance
   always_comb begin
      issue = 1'b0;
      flush = 1'b0;
      if (state == RUN) begin
         flush = w_redir;
         issue = w_rst_n && (occupancy < (CW+1)'(DEPTH)) && !w_redir && !w_halt;
      end
   end

   // Counting the inflight read against capacity is what makes overflow impossible.
   assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign push      = inflight && !flush;
   assign pop       = w_valid && w_ready && !flush;
   assign din       = '{ir: w_imem_data, pc: issue_pc};

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         pc       <= '0;
         issue_pc <= '0;
         inflight <= 1'b0;
      end else if (flush) begin
         pc       <= {w_redir_pc[31:2], 2'b00};
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc       <= pc + 32'd4;
            issue_pc <= pc;
         end
      end
   end

   m_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (w_clk),
      .rst_n (w_rst_n),
      .push  (push),
      .pop   (pop),
      .clear (flush),
      .din   (din),
      .head  (head),
      .count (count),
      .empty (empty)
   );

   assign w_imem_re   = issue;
   assign w_imem_addr = pc[AW+1:2];
   assign w_valid     = !empty;
   assign w_ir        = empty ? NOP_INSTR : head.ir;
   assign w_pc        = empty ? 32'd0 : head.pc;
   assign w_pc4       = empty ? 32'd0 : head.pc + 32'd4;
   assign w_state     = state;

`ifdef FETCH_QUEUE_STATS_EN
   // A flush discards every queued entry plus a cancelled inflight read.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_nfetch <= '0;
         r_nflush <= '0;
      end else begin
         if (pop)   r_nfetch <= r_nfetch + 32'd1;
         if (flush) r_nflush <= r_nflush + 32'(count) + 32'(inflight);
      end
   end
`endif

endmodule

// File: tb/tb_m_fetch_queue.sv
// Directed bench for m_fetch_queue (DEPTH=4, AW=12) with an imem model where imem[k]=k.
// Checks the FETCH_QUEUE_STATS_EN flush counter when that macro is defined.
module tb_m_fetch_queue;
   import fetch_pkg::*;

   logic          w_clk = 1'b0;
   logic          w_rst_n;
   logic          w_redir;
   logic [31:0]   w_redir_pc;
   logic          w_halt;
   logic          w_imem_re;
   logic [11:0]   w_imem_addr;
   logic [31:0]   w_imem_data;
   logic          w_valid;
   logic          w_ready;
   logic [31:0]   w_ir;
   logic [31:0]   w_pc;
   logic [31:0]   w_pc4;
   state_e        w_state;
`ifdef FETCH_QUEUE_STATS_EN
   logic [31:0]   r_nfetch;
   logic [31:0]   r_nflush;
   logic [31:0]   flush_before;
`endif

   int tests = 0;
   int fails = 0;

   always #5 w_clk = ~w_clk;

   m_fetch_queue #(.DEPTH(4), .AW(12)) dut (
      .w_clk       (w_clk),
      .w_rst_n     (w_rst_n),
      .w_redir     (w_redir),
      .w_redir_pc  (w_redir_pc),
      .w_halt      (w_halt),
      .w_imem_re   (w_imem_re),
      .w_imem_addr (w_imem_addr),
      .w_imem_data (w_imem_data),
      .w_valid     (w_valid),
      .w_ready     (w_ready),
      .w_ir        (w_ir),
      .w_pc        (w_pc),
      .w_pc4       (w_pc4),
      .w_state     (w_state)
`ifdef FETCH_QUEUE_STATS_EN
      ,
      .r_nfetch    (r_nfetch),
      .r_nflush    (r_nflush)
`endif
   );

   // Synchronous-read instruction memory holding imem[k] = k
   always @(posedge w_clk) begin
      if (w_imem_re) w_imem_data <= 32'(w_imem_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                           input logic [31:0] pc4);
      chk({tag, "_valid"}, 32'(w_valid), 32'd1);
      chk({tag, "_pc"},    w_pc,  pc);
      chk({tag, "_ir"},    w_ir,  ir);
      chk({tag, "_pc4"},   w_pc4, pc4);
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_valid"}, 32'(w_valid), 32'd0);
      chk({tag, "_ir"},    w_ir,  NOP_INSTR);
      chk({tag, "_pc"},    w_pc,  32'd0);
      chk({tag, "_pc4"},   w_pc4, 32'd0);
   endtask

   task automatic step();
      @(posedge w_clk);
      #1;
   endtask

   initial begin
      w_rst_n     = 1'b0;
      w_redir     = 1'b0;
      w_redir_pc  = '0;
      w_halt      = 1'b0;
      w_ready     = 1'b1;
      w_imem_data = '0;
      step();
      step();
      chk_empty("reset");
      chk("reset_re", 32'(w_imem_re), 32'd0);
      chk("reset_state", 32'(w_state), 32'(RUN));

      // Release: first valid two edges later, then one instruction per cycle
      w_rst_n = 1'b1;
      #1;
      chk("rel_c0_re", 32'(w_imem_re), 32'd1);
      chk("rel_c0_addr", 32'(w_imem_addr), 32'd0);
      chk("rel_c0_valid", 32'(w_valid), 32'd0);
      step();
      chk("rel_c1_valid", 32'(w_valid), 32'd0);
      chk("rel_c1_addr", 32'(w_imem_addr), 32'd1);
      step();
      chk_head("stream0", 32'd0, 32'd0, 32'd4);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk_head("stream", 32'(4*k), 32'(k), 32'(4*k+4));
      end

      // Back-pressure: queue fills to exactly DEPTH and stops reading
      w_ready = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk_head("full", 32'd20, 32'd5, 32'd24);
      chk("full_re", 32'(w_imem_re), 32'd0);
      w_ready = 1'b1;
      #1;
      chk_head("drain0", 32'd20, 32'd5, 32'd24);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_head("drain", 32'(20+4*i), 32'(5+i), 32'(24+4*i));
      end

      // Redirect while queue plus inflight read fill capacity, coinciding with pop and push
      w_ready = 1'b0;
      step();
      chk_head("pre_redir", 32'd40, 32'd10, 32'd44);
      chk("pre_redir_re", 32'(w_imem_re), 32'd0);
`ifdef FETCH_QUEUE_STATS_EN
      flush_before = r_nflush;
`endif
      w_redir    = 1'b1;
      w_redir_pc = 32'h00000043;
      w_ready    = 1'b1;
      step();
      w_redir = 1'b0;
      #1;
      chk_empty("post_redir");
      chk("post_redir_re", 32'(w_imem_re), 32'd1);
      chk("post_redir_addr", 32'(w_imem_addr), 32'h10);
`ifdef FETCH_QUEUE_STATS_EN
      chk("nflush", r_nflush, flush_before + 32'd4);
`endif
      step();
      chk("redir_c2_valid", 32'(w_valid), 32'd0);
      step();
      chk_head("redir_first", 32'h40, 32'h10, 32'h44);
      step();
      chk_head("redir_second", 32'h44, 32'h11, 32'h48);

      // Redirect near the top of the address space; issue suppressed that cycle
      w_redir    = 1'b1;
      w_redir_pc = 32'hFFFFFFF8;
      #1;
      chk("redir_suppress_re", 32'(w_imem_re), 32'd0);
      step();
      w_redir = 1'b0;
      #1;
      chk("wrap_addr", 32'(w_imem_addr), 32'hFFE);
      step();
      step();
      chk_head("wrap0", 32'hFFFFFFF8, 32'hFFE, 32'hFFFFFFFC);
      step();
      chk_head("wrap1", 32'hFFFFFFFC, 32'hFFF, 32'h00000000);
      step();
      chk_head("wrap2", 32'h00000000, 32'h0, 32'h00000004);

      // Asynchronous reset mid-stream clears outputs before any clock edge
      w_rst_n = 1'b0;
      #1;
      chk_empty("async_rst");
      chk("async_rst_re", 32'(w_imem_re), 32'd0);
      step();
      chk("rst_hold_valid", 32'(w_valid), 32'd0);
      w_rst_n = 1'b1;
      #1;
      chk("restart_addr", 32'(w_imem_addr), 32'd0);
      step();
      chk("restart_c1_valid", 32'(w_valid), 32'd0);
      step();
      chk_head("restart", 32'd0, 32'd0, 32'd4);

      // Halt with three entries queued and one read inflight
      w_ready = 1'b0;
      step();
      step();
      chk_head("pre_halt", 32'd0, 32'd0, 32'd4);
      w_halt = 1'b1;
      #1;
      chk("halt_re", 32'(w_imem_re), 32'd0);
      step();
      w_halt = 1'b0;
      #1;
      chk("halted_state", 32'(w_state), 32'(HALTED));
      chk("halted_re", 32'(w_imem_re), 32'd0);
      w_ready    = 1'b1;
      w_redir    = 1'b1;
      w_redir_pc = 32'h00000100;
      #1;
      chk_head("halt_drain0", 32'd0, 32'd0, 32'd4);
      step();
      w_redir = 1'b0;
      chk_head("halt_drain1", 32'd4, 32'd1, 32'd8);
      step();
      chk_head("halt_drain2", 32'd8, 32'd2, 32'd12);
      step();
      chk_head("halt_drain3", 32'd12, 32'd3, 32'd16);
      step();
      chk_empty("halt_empty");
      chk("halt_empty_re", 32'(w_imem_re), 32'd0);
      for (int i = 0; i < 4; i++) step();
      chk("halt_sticky_valid", 32'(w_valid), 32'd0);
      chk("halt_sticky_re", 32'(w_imem_re), 32'd0);
      chk("halt_sticky_state", 32'(w_state), 32'(HALTED));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
